// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero count and normalize. Stage 1 registers per-group zero
// flags; stage 2 priority-encodes them, counts in-group zeros and barrel-shifts.
module lzd_norm_pipe #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned GROUP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(WIDTH+1)-1:0] out_lzc_o,
  output logic                       out_zero_o
);

  localparam int unsigned LZC_W = $clog2(WIDTH + 1);
  localparam int unsigned G     = WIDTH / GROUP;
  localparam int unsigned F_W   = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned P_W   = $clog2(GROUP);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [G-1:0]     r_s1_zf;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_load_s1;
  logic [G-1:0]     w_zf;
  logic             w_found;
  logic [F_W-1:0]   w_f;
  logic [GROUP-1:0] w_grp;
  logic [P_W-1:0]   w_p;
  logic [LZC_W-1:0] w_lzc;
  logic [WIDTH-1:0] w_norm;

  assign w_s2_adv   = !out_valid_o || out_ready_i;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready_o = w_s1_adv || flush_i;
  assign w_load_s1  = in_valid_i && w_s1_adv && !flush_i;

  // Group k = 0 is the most significant group.
  always_comb begin
    w_zf = '0;
    for (int k = 0; k < int'(G); k++) begin
      w_zf[k] = &(~in_data_i[WIDTH-1-k*GROUP -: GROUP]);
    end
  end

  // First non-zero group, then leading zeros inside that group.
  always_comb begin
    w_found = 1'b0;
    w_f     = '0;
    for (int k = 0; k < int'(G); k++) begin
      if (!w_found && !r_s1_zf[k]) begin
        w_found = 1'b1;
        w_f     = F_W'(k);
      end
    end

    w_grp = '0;
    for (int k = 0; k < int'(G); k++) begin
      if (w_f == F_W'(k)) begin
        w_grp = r_s1_data[WIDTH-1-k*GROUP -: GROUP];
      end
    end

    // Scanning upward, the highest set bit assigns last and wins.
    w_p = '0;
    for (int b = 0; b < int'(GROUP); b++) begin
      if (w_grp[b]) begin
        w_p = P_W'(int'(GROUP) - 1 - b);
      end
    end

    if (w_found) begin
      w_lzc  = LZC_W'(w_f) * LZC_W'(GROUP) + LZC_W'(w_p);
      w_norm = r_s1_data << w_lzc;
    end else begin
      w_lzc  = LZC_W'(WIDTH);
      w_norm = '0;
    end
  end

  // Stage 1: capture mantissa and group zero flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_zf    <= '0;
    end else begin
      if (flush_i) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_adv) begin
        r_s1_valid <= in_valid_i;
      end
      if (w_load_s1) begin
        r_s1_data <= in_data_i;
        r_s1_zf   <= w_zf;
      end
    end
  end

  // Stage 2 output registers; hold while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_lzc_o   <= '0;
      out_zero_o  <= 1'b0;
    end else begin
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (w_s2_adv) begin
        out_valid_o <= r_s1_valid;
      end
      if (w_s2_adv) begin
        out_data_o <= w_norm;
        out_lzc_o  <= w_lzc;
        out_zero_o <= !w_found;
      end
    end
  end

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Scoreboard bench for lzd_norm_pipe: directed boundaries, backpressure,
// random streaming, flush and asynchronous reset.
module tb_lzd_norm_pipe;

  typedef struct packed {
    logic [47:0] d;
    logic [5:0]  l;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [47:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [47:0] out_data_o;
  logic [5:0]  out_lzc_o;
  logic        out_zero_o;

  lzd_norm_pipe #(.WIDTH(48), .GROUP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_lzc_o  (out_lzc_o),
    .out_zero_o (out_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t nxt;
  logic acc;
  logic rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: count zeros from the MSB bit by bit, independent of grouping.
  function automatic exp_t model(input logic [47:0] x);
    exp_t e;
    e.l = 6'd48;
    for (int i = 0; i < 48; i++) if (x[i]) e.l = 6'(47 - i);
    e.d = (e.l == 6'd48) ? 48'h0 : (x << e.l);
    e.z = (x == 48'h0);
    return e;
  endfunction

  // One clock: compare/push at the falling edge, return just after the rising edge.
  task automatic cycle();
    exp_t e;
    if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(out_valid_o), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data_o), 64'(e.d));
        chk("out_lzc",  64'(out_lzc_o),  64'(e.l));
        chk("out_zero", 64'(out_zero_o), 64'(e.z));
      end
    end
    acc = in_valid_i && in_ready_o && !flush_i;
    if (acc) sb.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] d);
    int n;
    in_valid_i = 1'b1;
    in_data_i  = d;
    nxt        = model(d);
    n          = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 64'(acc), 64'h1);
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid_i = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'h0);
  endtask

  // Directed single transfer on an empty pipe with a fixed expected result.
  task automatic dir(input logic [47:0] d, input logic [47:0] ed, input logic [5:0] el,
                     input logic ez);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = d;
    nxt         = '{d: ed, l: el, z: ez};
    cycle();
    in_valid_i = 1'b0;
    chk("dir_accept", 64'(acc), 64'h1);
    chk("dir_lat1", 64'(out_valid_o), 64'h0);
    cycle();
    chk("dir_lat2", 64'(out_valid_o), 64'h1);
    cycle();
    chk("dir_popped", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    logic [63:0] r;
    logic [47:0] d;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b1;
    nxt         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid_o), 64'h0);
    chk("rst_lzc",   64'(out_lzc_o),   64'h0);
    chk("rst_data",  64'(out_data_o),  64'h0);
    chk("rst_zero",  64'(out_zero_o),  64'h0);
    rst_n = 1'b1;
    cycle();
    chk("idle_ready", 64'(in_ready_o), 64'h1);

    dir(48'h0000_1000_0000, 48'h8000_0000_0000, 6'd19, 1'b0);
    dir(48'h8000_0000_0000, 48'h8000_0000_0000, 6'd0,  1'b0);
    dir(48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0);
    dir(48'h0,              48'h0,              6'd48, 1'b1);
    dir(48'h0F00_0000_0000, 48'hF000_0000_0000, 6'd4,  1'b0);
    dir(48'h0010_0000_0000, 48'h8000_0000_0000, 6'd11, 1'b0);
    dir(48'h0000_0000_0F0A, 48'hF0A0_0000_0000, 6'd36, 1'b0);

    // Backpressure: four back-to-back inputs with a stalled consumer.
    out_ready_i = 1'b0;
    send(48'h1);
    send(48'h3);
    chk("bp_ready_drop", 64'(in_ready_o), 64'h0);
    in_valid_i = 1'b1;
    in_data_i  = 48'h0000_00FF_0000;
    nxt        = model(in_data_i);
    repeat (3) begin
      cycle();
      chk("bp_not_acc",    64'(acc),         64'h0);
      chk("bp_hold_valid", 64'(out_valid_o), 64'h1);
      chk("bp_hold_data",  64'(out_data_o),  64'h8000_0000_0000);
      chk("bp_hold_lzc",   64'(out_lzc_o),   64'd47);
    end
    out_ready_i = 1'b1;
    send(48'h0000_00FF_0000);
    send(48'h7FFF_FFFF_FFFF);
    drain(20);

    // Random streaming with random consumer readiness.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom};
      d = r[47:0] >> $urandom_range(0, 47);
      if ($urandom_range(0, 9) == 0) d = '0;
      send(d);
    end
    drain(100);
    rand_rdy    = 1'b0;
    out_ready_i = 1'b1;

    // Flush with both stages full; handshake in the flush cycle is dropped.
    out_ready_i = 1'b0;
    send(48'h0000_0000_00F0);
    send(48'h0000_0001_0000);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 48'h0000_0000_0002;
    #1;
    chk("flush_ready", 64'(in_ready_o), 64'h1);
    cycle();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_valid", 64'(out_valid_o), 64'h0);
    sb.delete();
    out_ready_i = 1'b1;
    cycle();
    chk("flush_s1_clear", 64'(out_valid_o), 64'h0);
    dir(48'h0000_0400_0000, 48'h8000_0000_0000, 6'd21, 1'b0);

    // Asynchronous reset mid-stream.
    send(48'h0000_0000_1234);
    send(48'h00AB_0000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'h0);
    chk("arst_lzc",   64'(out_lzc_o),   64'h0);
    sb.delete();
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      cycle();
      chk("post_rst_idle", 64'(out_valid_o), 64'h0);
    end
    dir(48'h0000_0000_0100, 48'h8000_0000_0000, 6'd39, 1'b0);
    chk("sb_leftover", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lzd_norm_pipe.md
Name: lzd_norm_pipe

Overview:
Two-stage pipelined leading-zero count and normalization stage for the MAC datapath. Stage 1 splits the unnormalized mantissa into fixed-size groups and registers one all-zero flag per group. Stage 2 combines those flags with an in-group priority encode, produces the leading-zero count, and left-shifts the mantissa so its MSB is 1. Sits between the adder/accumulator output and the exponent-adjust/rounding stage, with valid/ready flow control on both sides.

Parameters:
WIDTH, 48, mantissa width in bits; must be a multiple of GROUP.
GROUP, 4, bits per zero-detect group; must be ≥2.
LZC_W, $clog2(WIDTH+1), width of the leading-zero count (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush_i  input  1  synchronous pipeline flush; invalidates both stages.
in_valid_i  input  1  upstream data valid.
in_ready_o  output  1  block can accept in_data_i this cycle.
in_data_i  input  WIDTH  unnormalized mantissa; bit WIDTH-1 is the MSB.
out_valid_o  output  1  result valid.
out_ready_i  input  1  downstream accepts the result.
out_data_o  output  WIDTH  in_data_i << out_lzc_o, zero-filled from the LSB.
out_lzc_o  output  LZC_W  number of leading zeros, 0..WIDTH.
out_zero_o  output  1  input was all zeros.

Behaviour:
- Reset (rst_n low, async): s1_valid, out_valid_o, out_zero_o = 0; out_data_o, out_lzc_o, and all stage-1 registers = 0. Release is synchronous to clk.
- Groups: G = WIDTH/GROUP. Group k covers bits [WIDTH-1-k*GROUP -: GROUP], with k=0 the most significant. Flag zf[k] = 1 iff every bit of group k is 0. Equivalently, zf[k] is the AND of the inverted group bits.
- Stage 1 captures in_data_i and zf[G-1:0] when in_valid_i && in_ready_o.
- Stage 2, from the stage-1 registers:
  - f = index of the first k with zf[k] = 0.
  - p = leading-zero count within group f.
  - lzc = f*GROUP + p.
  - If all zf are set: lzc = WIDTH, out_zero_o = 1, out_data_o = 0.
- Stage 2 is a single combinational cycle feeding the output registers. The shift is a barrel shift by lzc.
- Latency: exactly 2 clk edges from input handshake to out_valid_o, with no stalls. Throughput is 1 result per cycle.
- Flow control:
  - s2_adv = !out_valid_o || out_ready_i.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready_o = s1_adv (combinational, no dependency on in_valid_i).
- Output register update:
  - Loads from stage 1 when s2_adv; out_valid_o <= s1_valid.
  - When !s2_adv, out_valid_o, out_data_o, out_lzc_o and out_zero_o hold stable until accepted.
- Stage 1 holds its contents while !s1_adv.
- Simultaneous accept on output and input in the same cycle: both stages advance; no bubble, no loss, no duplication.
- out_valid_o must not depend combinationally on out_ready_i.
- flush_i (synchronous):
  - Clears s1_valid and out_valid_o next edge. Data registers may keep stale values.
  - A handshake in the flush cycle is dropped.
  - in_ready_o is forced 1 during flush.
- Reset mid-operation: all in-flight data is discarded; no output valid after reset until a new input is accepted.
- Outputs are don't-care when out_valid_o = 0, except their reset values.

Test Plan:
- Basic, WIDTH=48, GROUP=4, out_ready_i=1: in_data_i=48'h0000_1000_0000 -> 2 cycles later out_valid_o=1, out_lzc_o=19, out_data_o=48'h8000_0000_0000, out_zero_o=0.
- Boundaries:
  - 48'h8000_0000_0000 -> lzc 0, data unchanged.
  - 48'h0000_0000_0001 -> lzc 47, data 48'h8000_0000_0000.
  - 48'h0 -> lzc 48, data 0, zero 1.
- Group edges: 48'h0F00_0000_0000 -> lzc 4; 48'h0010_0000_0000 -> lzc 11; data MSB = 1 in both.
- Backpressure: send 4 back-to-back inputs with out_ready_i=0 for 5 cycles.
  - in_ready_o drops after 2 accepts; output holds the first result stable.
  - On release, all 4 results emerge in order, 1 per cycle, with no loss or duplication.
- Streaming with random out_ready_i over 1000 random inputs (10% zero) -> scoreboard matches reference lzc/shift; order is preserved.
- Flush and reset:
  - flush_i with both stages full -> out_valid_o = 0 next cycle; the next input emerges 2 cycles after its handshake.
  - rst_n low mid-stream -> out_valid_o and out_lzc_o read 0 asynchronously.
